// File: rtl/countdown_timer_mmss.sv
//------------------------------------------------------------------------------
// countdown_timer_mmss
//
// Purpose:
//   Loadable mm:ss kitchen-style countdown timer. The count is kept as four
//   BCD digits and goes down by one second on each clk_sec pulse while the
//   timer runs. Button pulses start, pause, resume, load and clear the timer.
//   On reaching 00:00 it pulses timeout for one cycle and holds alarm high for
//   ALARM_SEC seconds, or until the user acknowledges it with btn_start.
//
// Parameters:
//   ALARM_SEC  alarm duration in clk_sec ticks (1..31)
//   MIN10_MAX  largest minutes-tens digit (5 -> 59:59, 9 -> 99:59)
//
// Ports:
//   clk                       system clock
//   reset_n                   synchronous active-low reset
//   clk_sec                   one-cycle pulse per second
//   btn_start                 one-cycle pulse: start / pause / resume / ack
//   btn_load                  one-cycle pulse: load the set_* digits
//   btn_clear                 one-cycle pulse: abort and zero the count
//   set_sec1 .. set_min10     BCD preset digits
//   sec1 .. min10             current BCD count (registered)
//   running                   high while counting
//   alarm                     high while the alarm sounds
//   timeout                   one-cycle pulse when the count reaches 00:00
//
// Build option:
//   COUNTDOWN_AUTO_RELOAD_EN  when defined, the last loaded value is kept in a
//                             shadow register and restored when the alarm ends
//                             (by timing out or by btn_start acknowledge).
//------------------------------------------------------------------------------
module countdown_timer_mmss #(
    parameter int ALARM_SEC = 5,
    parameter int MIN10_MAX = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_sec,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic       btn_clear,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec10,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min10,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       running,
    output logic       alarm,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_ALARM
    } state_t;

    typedef struct packed {
        logic [3:0] min10;
        logic [3:0] min1;
        logic [3:0] sec10;
        logic [3:0] sec1;
    } bcd_t;

    localparam logic [3:0] MIN10_LIM  = 4'(MIN10_MAX);
    localparam logic [4:0] ALARM_LAST = 5'(ALARM_SEC - 1);

    state_t     state, state_nxt;
    bcd_t       count, count_nxt;
    bcd_t       load_val;
    bcd_t       dec_val;
    bcd_t       reload_val;
    logic [4:0] alarm_cnt, alarm_cnt_nxt;
    logic       timeout_nxt;
    logic       at_expiry;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    bcd_t       shadow, shadow_nxt;
`endif

    // Preset digits are clamped into the legal BCD range of each position so
    // that a bad preset can never put an illegal digit on the display.
    always_comb begin
        load_val.sec1  = (set_sec1  > 4'd9)      ? 4'd9      : set_sec1;
        load_val.sec10 = (set_sec10 > 4'd5)      ? 4'd5      : set_sec10;
        load_val.min1  = (set_min1  > 4'd9)      ? 4'd9      : set_min1;
        load_val.min10 = (set_min10 > MIN10_LIM) ? MIN10_LIM : set_min10;
    end

    // One-second BCD decrement. Each digit that is already zero wraps to its
    // maximum and borrows from the next digit up. The minutes-tens digit is
    // only reached when the count is at least 10:00, so it never underflows.
    always_comb begin
        dec_val = count;
        if (count.sec1 != 4'd0) begin
            dec_val.sec1 = count.sec1 - 4'd1;
        end else begin
            dec_val.sec1 = 4'd9;
            if (count.sec10 != 4'd0) begin
                dec_val.sec10 = count.sec10 - 4'd1;
            end else begin
                dec_val.sec10 = 4'd5;
                if (count.min1 != 4'd0) begin
                    dec_val.min1 = count.min1 - 4'd1;
                end else begin
                    dec_val.min1  = 4'd9;
                    dec_val.min10 = count.min10 - 4'd1;
                end
            end
        end
    end

    // A tick at 00:01 expires the timer. A count of 00:00 in RUN (possible
    // only by loading zero while paused and resuming) is treated the same way
    // instead of wrapping around to the top of the range.
    assign at_expiry = (count.min10 == 4'd0) && (count.min1 == 4'd0) &&
                       (count.sec10 == 4'd0) && (count.sec1 <= 4'd1);

    // The value the digits take when the alarm ends: the shadow copy of the
    // last load when auto-reload is built in, otherwise 00:00.
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    assign reload_val = shadow;
`else
    assign reload_val = '0;
`endif

    // Next-state and next-count logic. Events are handled in priority order
    // clear > load > start > tick, so only one of them acts in any cycle.
    // A load in RUN or ALARM is ignored and lets lower-priority events act.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        alarm_cnt_nxt = alarm_cnt;
        timeout_nxt   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        shadow_nxt    = shadow;
`endif

        if (btn_clear) begin
            state_nxt     = ST_IDLE;
            count_nxt     = '0;
            alarm_cnt_nxt = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_nxt    = '0;
`endif
        end else if (btn_load && (state == ST_IDLE || state == ST_PAUSE)) begin
            count_nxt  = load_val;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow_nxt = load_val;
`endif
        end else if (btn_start) begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_nxt = ST_PAUSE;
                end
                ST_PAUSE: begin
                    state_nxt = ST_RUN;
                end
                ST_ALARM: begin
                    state_nxt = ST_IDLE;
                    count_nxt = reload_val;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end else if (clk_sec) begin
            case (state)
                ST_RUN: begin
                    if (at_expiry) begin
                        state_nxt     = ST_ALARM;
                        count_nxt     = '0;
                        alarm_cnt_nxt = '0;
                        timeout_nxt   = 1'b1;
                    end else begin
                        count_nxt = dec_val;
                    end
                end
                ST_ALARM: begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_nxt     = ST_IDLE;
                        count_nxt     = reload_val;
                        alarm_cnt_nxt = '0;
                    end else begin
                        alarm_cnt_nxt = alarm_cnt + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers. running and alarm are decoded from the next
    // state so that they change in the same cycle as the state itself.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            alarm_cnt <= '0;
            running   <= 1'b0;
            alarm     <= 1'b0;
            timeout   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            running   <= (state_nxt == ST_RUN);
            alarm     <= (state_nxt == ST_ALARM);
            timeout   <= timeout_nxt;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            shadow    <= shadow_nxt;
`endif
        end
    end

    assign sec1  = count.sec1;
    assign sec10 = count.sec10;
    assign min1  = count.min1;
    assign min10 = count.min10;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
//------------------------------------------------------------------------------
// tb_countdown_timer_mmss
//
// Self-checking bench for countdown_timer_mmss with default parameters.
// A reference model keeps the count as a plain number of seconds and the
// mode as a small integer; expected digits come from division of that total.
// Honours COUNTDOWN_AUTO_RELOAD_EN when it is defined for the build.
//------------------------------------------------------------------------------
module tb_countdown_timer_mmss;

    localparam int ALARM_SEC = 5;
    localparam int MIN10_MAX = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_ALARM = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_sec = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] set_sec1 = 4'd0;
    logic [3:0] set_sec10 = 4'd0;
    logic [3:0] set_min1 = 4'd0;
    logic [3:0] set_min10 = 4'd0;
    logic [3:0] sec1, sec10, min1, min10;
    logic       running, alarm, timeout;

    logic [18:0] obs;
    assign obs = {min10, min1, sec10, sec1, running, alarm, timeout};

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_mode    = M_IDLE;
    int m_total   = 0;
    int m_ticks   = 0;
    int m_shadow  = 0;
    bit m_timeout = 1'b0;

    countdown_timer_mmss #(
        .ALARM_SEC(ALARM_SEC),
        .MIN10_MAX(MIN10_MAX)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_sec  (clk_sec),
        .btn_start(btn_start),
        .btn_load (btn_load),
        .btn_clear(btn_clear),
        .set_sec1 (set_sec1),
        .set_sec10(set_sec10),
        .set_min1 (set_min1),
        .set_min10(set_min10),
        .sec1     (sec1),
        .sec10    (sec10),
        .min1     (min1),
        .min10    (min10),
        .running  (running),
        .alarm    (alarm),
        .timeout  (timeout)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic int clampd(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // value the display shows after the alarm ends
    function automatic int reload_total();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        return m_shadow;
`else
        return 0;
`endif
    endfunction

    // expected {min10,min1,sec10,sec1,running,alarm,timeout}
    function automatic logic [18:0] expWord();
        int mins;
        int secs;
        mins = m_total / 60;
        secs = m_total % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                m_mode == M_RUN, m_mode == M_ALARM, m_timeout};
    endfunction

    // advance the reference model by one clock edge
    task automatic model_step(input bit rst, input bit clr, input bit load,
                              input bit start, input bit tick,
                              input int m10, input int m1, input int s10, input int s1);
        m_timeout = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_total = 0; m_ticks = 0; m_shadow = 0;
        end else if (clr) begin
            m_mode = M_IDLE; m_total = 0; m_shadow = 0;
        end else if (load && (m_mode == M_IDLE || m_mode == M_PAUSE)) begin
            m_total = clampd(m10, MIN10_MAX) * 600 + clampd(m1, 9) * 60 +
                      clampd(s10, 5) * 10 + clampd(s1, 9);
            m_shadow = m_total;
        end else if (start) begin
            if (m_mode == M_IDLE && m_total != 0) m_mode = M_RUN;
            else if (m_mode == M_RUN) m_mode = M_PAUSE;
            else if (m_mode == M_PAUSE) m_mode = M_RUN;
            else if (m_mode == M_ALARM) begin
                m_mode = M_IDLE; m_total = reload_total();
            end
        end else if (tick) begin
            if (m_mode == M_RUN) begin
                if (m_total <= 1) begin
                    m_total = 0; m_mode = M_ALARM; m_ticks = 0; m_timeout = 1'b1;
                end else begin
                    m_total = m_total - 1;
                end
            end else if (m_mode == M_ALARM) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == ALARM_SEC) begin
                    m_mode = M_IDLE; m_total = reload_total();
                end
            end
        end
    endtask

    // drive one cycle of inputs at the falling edge, step the model, and
    // return 1 ns after the rising edge with the pulses removed
    task automatic applyStimulus(input bit rst, input bit clr, input bit load,
                                 input bit start, input bit tick,
                                 input logic [3:0] m10, input logic [3:0] m1,
                                 input logic [3:0] s10, input logic [3:0] s1);
        @(negedge clk);
        reset_n   = ~rst;
        btn_clear = clr;
        btn_load  = load;
        btn_start = start;
        clk_sec   = tick;
        set_min10 = m10;
        set_min1  = m1;
        set_sec10 = s10;
        set_sec1  = s1;
        model_step(rst, clr, load, start, tick, int'(m10), int'(m1), int'(s10), int'(s1));
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        btn_clear = 1'b0;
        btn_load  = 1'b0;
        btn_start = 1'b0;
        clk_sec   = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 19'h0) begin
            errors++;
            $display("[TB] FAIL reset_values: got=%h exp=%h", obs, 19'h0);
        end
    endtask

    task automatic test_clamp();
        applyStimulus(0, 0, 1, 0, 0, 4'd8, 4'd3, 4'd7, 4'd12);
        checks++;
        if (obs[18:3] !== 16'h5359 || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL load_clamp: got=%h exp=%h", obs, expWord());
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_full_minute();
        int pulses;
        pulses = 0;
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd1, 4'd0, 4'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL minute_start: got=%h exp=%h", obs, expWord());
        end
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
            pulses += int'(timeout);
            checks++;
            if (obs !== expWord()) begin
                errors++;
                $display("[TB] FAIL minute_tick%0d: got=%h exp=%h", i, obs, expWord());
            end
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            pulses += int'(timeout);
            checks++;
            if (obs !== expWord()) begin
                errors++;
                $display("[TB] FAIL minute_gap%0d: got=%h exp=%h", i, obs, expWord());
            end
        end
        checks++;
        if (pulses != 1 || alarm !== 1'b1) begin
            errors++;
            $display("[TB] FAIL minute_timeout_once: pulses=%0d alarm=%b exp pulses=1 alarm=1", pulses, alarm);
        end
    endtask

    task automatic test_alarm_expiry();
        for (int i = 0; i < ALARM_SEC; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
            checks++;
            if (obs !== expWord() || alarm !== (i < ALARM_SEC - 1)) begin
                errors++;
                $display("[TB] FAIL alarm_tick%0d: got=%h exp=%h", i, obs, expWord());
            end
        end
    endtask

    task automatic test_pause_resume();
        applyStimulus(0, 0, 1, 0, 0, 4'd1, 4'd0, 4'd0, 4'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs[18:3] !== 16'h0959 || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL pause_first_tick: got=%h exp=%h", obs, expWord());
        end
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== {16'h0959, 3'b000} || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL pause_wins: got=%h exp=%h", obs, expWord());
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
            checks++;
            if (obs !== expWord()) begin
                errors++;
                $display("[TB] FAIL pause_hold%0d: got=%h exp=%h", i, obs, expWord());
            end
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== {16'h0959, 3'b100} || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL pause_resume: got=%h exp=%h", obs, expWord());
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_alarm_ack();
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (alarm !== 1'b1 || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL ack_still_alarm: got=%h exp=%h", obs, expWord());
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (alarm !== 1'b0 || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL ack_drops: got=%h exp=%h", obs, expWord());
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_in_run_and_clear();
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd3, 4'd1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 4'd4, 4'd4, 4'd4, 4'd4);
        checks++;
        if (obs !== {16'h0030, 3'b100} || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL load_in_run: got=%h exp=%h", obs, expWord());
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        checks++;
        if (obs !== {16'h0020, 3'b100} || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL run_to_20: got=%h exp=%h", obs, expWord());
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== 19'h0 || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL clear_in_run: got=%h exp=%h", obs, expWord());
        end
    endtask

    task automatic test_reset_mid_run();
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd2);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== 19'h0 || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got=%h exp=%h", obs, expWord());
        end
    endtask

    task automatic test_auto_reload();
        logic [15:0] want;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        want = 16'h0003;
`else
        want = 16'h0000;
`endif
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd3);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3 + ALARM_SEC; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        end
        checks++;
        if (obs !== {want, 3'b000} || obs !== expWord()) begin
            errors++;
            $display("[TB] FAIL after_alarm_digits: got=%h exp=%h", obs, {want, 3'b000});
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        int r;
        bit rst, clr, load, start, tick;
        logic [3:0] m10, m1, s10, s1;
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            rst   = (r == 99);
            clr   = (r < 2);
            load  = (r >= 2 && r < 10);
            start = (r >= 10 && r < 20);
            tick  = (r >= 16 && r < 60);
            if ($urandom_range(0, 3) == 0) begin
                m10 = 4'($urandom_range(0, 15));
                m1  = 4'($urandom_range(0, 15));
                s10 = 4'($urandom_range(0, 15));
                s1  = 4'($urandom_range(0, 15));
                if (m10 == 0 && m1 == 0 && s10 == 0 && s1 == 0) s1 = 4'd1;
            end else begin
                m10 = 4'd0;
                m1  = 4'd0;
                s10 = 4'($urandom_range(0, 2));
                s1  = 4'($urandom_range(1, 9));
            end
            applyStimulus(rst, clr, load, start, tick, m10, m1, s10, s1);
            checks++;
            if (obs !== expWord()) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got=%h exp=%h", i, obs, expWord());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_full_minute();
        test_alarm_expiry();
        test_pause_resume();
        test_alarm_ack();
        test_load_in_run_and_clear();
        test_reset_mid_run();
        test_auto_reload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
